// File: rtl/par2ser_shifter_if.sv
// par2ser_shifter_if: word handshake into the shifter and the serial stream out of it.
`default_nettype none

interface par2ser_shifter_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output s_valid, s_data,
    input  s_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, ser_out, ser_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/par2ser_shifter.sv
// par2ser_shifter: parallel word to gapless serial bit stream with valid/ready intake.
// Optional trailing even-parity bit when PAR2SER_PARITY_EN is defined.
`default_nettype none

module par2ser_shifter #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  par2ser_shifter_if.slave bus
);

  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic            IDLE_BIT = (IDLE_LEVEL != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef PAR2SER_PARITY_EN
    ,
    S_PARITY = 2'd2
`endif
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [WIDTH-1:0]  shreg;
  logic              ready_en;
  logic              ready, xfer, load, adv, done_nx;
  logic              ser_out_q, ser_valid_q, done_q;
  logic              first_bit, head_bit;
  logic [WIDTH-1:0]  load_shifted, shreg_shifted;
`ifdef PAR2SER_PARITY_EN
  logic              parity_q;
`endif

  assign first_bit     = (MSB_FIRST != 0) ? bus.s_data[WIDTH-1] : bus.s_data[0];
  assign head_bit      = (MSB_FIRST != 0) ? shreg[WIDTH-1]      : shreg[0];
  assign load_shifted  = (MSB_FIRST != 0) ? (bus.s_data << 1)   : (bus.s_data >> 1);
  assign shreg_shifted = (MSB_FIRST != 0) ? (shreg << 1)        : (shreg >> 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    ready    = 1'b0;
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    adv      = 1'b0;
    done_nx  = 1'b0;

    // Readiness depends only on state, counter and clr, so s_valid can never loop back into it.
    if (ready_en && !clr) begin
      case (state)
        S_IDLE:   ready = 1'b1;
`ifdef PAR2SER_PARITY_EN
        S_SHIFT:  ready = 1'b0;
        S_PARITY: ready = 1'b1;
`else
        S_SHIFT:  ready = (cnt == LAST);
`endif
        default:  ready = 1'b0;
      endcase
    end
    xfer = bus.s_valid && ready;

    case (state)
      S_IDLE: begin
        if (xfer) begin
          state_nx = S_SHIFT;
          cnt_nx   = '0;
          load     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt != LAST) begin
          cnt_nx = cnt + CW'(1);
          adv    = 1'b1;
        end else begin
          cnt_nx = '0;
`ifdef PAR2SER_PARITY_EN
          state_nx = S_PARITY;
`else
          if (xfer) load = 1'b1;
          else      state_nx = S_IDLE;
`endif
        end
      end
`ifdef PAR2SER_PARITY_EN
      S_PARITY: begin
        cnt_nx = '0;
        if (xfer) begin
          state_nx = S_SHIFT;
          load     = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase

    if (clr) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      load     = 1'b0;
      adv      = 1'b0;
    end

`ifdef PAR2SER_PARITY_EN
    done_nx = (state_nx == S_PARITY);
`else
    done_nx = (state_nx == S_SHIFT) && (cnt_nx == LAST);
`endif
  end

  // Outputs are registered from next-state values so a word loaded at edge N shows its first bit right after N.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg       <= '0;
      ready_en    <= 1'b0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PAR2SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      ready_en    <= 1'b1;
      ser_valid_q <= (state_nx != S_IDLE);
      done_q      <= done_nx;
      if (load) begin
        shreg     <= load_shifted;
        ser_out_q <= first_bit;
`ifdef PAR2SER_PARITY_EN
        parity_q  <= ^bus.s_data;
`endif
      end else if (adv) begin
        shreg     <= shreg_shifted;
        ser_out_q <= head_bit;
`ifdef PAR2SER_PARITY_EN
      end else if (state_nx == S_PARITY) begin
        ser_out_q <= parity_q;
`endif
      end else if (state_nx == S_IDLE) begin
        ser_out_q <= IDLE_BIT;
      end
    end
  end

  assign bus.s_ready   = ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_par2ser_shifter.sv
// tb_par2ser_shifter: an MSB-first/idle-high and an LSB-first/idle-low shifter fed the same stream,
// checked against a word/bit-index reference model, a vector table and hand sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_par2ser_shifter;

  localparam int W = 8;
`ifdef PAR2SER_PARITY_EN
  localparam int LAST_IDX = W;       // index W is the parity bit
`else
  localparam int LAST_IDX = W - 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic clr  = 1'b0;
  always #5 clk = ~clk;

  par2ser_shifter_if #(.WIDTH(W)) bus_m ();
  par2ser_shifter_if #(.WIDTH(W)) bus_l ();
  assign bus_l.s_valid = bus_m.s_valid;
  assign bus_l.s_data  = bus_m.s_data;

  par2ser_shifter #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1)) dut_m (
    .clk(clk), .rstn(rstn), .clr(clr), .bus(bus_m)
  );
  par2ser_shifter #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0)) dut_l (
    .clk(clk), .rstn(rstn), .clr(clr), .bus(bus_l)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: current word and index of the serial bit on the wire (-1 = idle).
  int           idx  = -1;
  logic [W-1:0] word = '0;
  bit           init = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic e_ready();
    return init && !clr && (idx < 0 || idx == LAST_IDX);
  endfunction

  function automatic logic e_bit(input bit msb);
    if (idx < 0)  return msb;              // msb instance idles high, lsb instance idles low
    if (idx >= W) return ^word;
    return msb ? word[W-1-idx] : word[idx];
  endfunction

  function automatic void model_update();
    logic x;
    x = e_ready() && bus_m.s_valid;
    if (clr)          idx = -1;
    else if (x)       begin idx = 0; word = bus_m.s_data; end
    else if (idx >= 0) idx = (idx == LAST_IDX) ? -1 : idx + 1;
    init = 1'b1;
  endfunction

  task automatic check_out();
    cmp("m.ser_valid", bus_m.ser_valid, idx >= 0);
    cmp("l.ser_valid", bus_l.ser_valid, idx >= 0);
    cmp("m.ser_out",   bus_m.ser_out,   e_bit(1'b1));
    cmp("l.ser_out",   bus_l.ser_out,   e_bit(1'b0));
    cmp("m.done",      bus_m.done,      idx == LAST_IDX);
    cmp("l.done",      bus_l.done,      idx == LAST_IDX);
    cmp("m.busy",      bus_m.busy,      idx >= 0);
    cmp("l.busy",      bus_l.busy,      idx >= 0);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic c);
    @(negedge clk);
    bus_m.s_valid = v;
    bus_m.s_data  = d;
    clr           = c;
    #1;
    cmp("s_ready", bus_m.s_ready, e_ready());
    cmp("l.s_ready", bus_l.s_ready, e_ready());
    @(posedge clk);
    model_update();
    #1;
    check_out();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn          = 1'b1;
    bus_m.s_valid = 1'b0;
    clr           = 1'b0;
    @(posedge clk);
    model_update();
    #1;
    check_out();
    cmp("rel.s_ready", bus_m.s_ready, 1'b1);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         c;
    logic         sv;
    logic         so;
    logic         dn;
  } vec_t;
  vec_t tbl[$];

  function automatic void tv(input logic v, input logic [W-1:0] d, input logic c,
                             input logic sv, input logic so, input logic dn);
    tbl.push_back('{v, d, c, sv, so, dn});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen[8];
    logic        exp4[8];
    logic [3:0]  hist;
    int          det;
    int          nv;

    bus_m.s_valid = 1'b1;
    bus_m.s_data  = 8'hFF;

    // Reset held with s_valid high
    repeat (3) begin
      @(negedge clk);
      check_out();
      cmp("rst.s_ready", bus_m.s_ready, 1'b0);
    end
    release_reset();

    // Vector table, MSB-first instance
`ifdef PAR2SER_PARITY_EN
    tv(1, 8'h07, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 0, 0); tv(0, 8'h00, 0, 1, 0, 0); tv(0, 8'h00, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 0, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 1, 0);
    tv(0, 8'h00, 0, 1, 1, 0);
    tv(0, 8'h00, 0, 1, 1, 1);
    tv(0, 8'h00, 0, 0, 1, 0);
`else
    tv(1, 8'h6D, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 1, 1);
    tv(0, 8'h00, 0, 0, 1, 0);
    tv(1, 8'hA5, 0, 1, 1, 0);
    tv(0, 8'h00, 0, 1, 0, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 0, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 1, 1);
    tv(1, 8'h3C, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 0, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 1, 0);
    tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 1, 0); tv(0, 8'h00, 0, 1, 0, 0);
    tv(0, 8'h00, 0, 1, 0, 1);
    tv(0, 8'h00, 0, 0, 1, 0);
`endif
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      cmp($sformatf("tbl[%0d].ser_valid", i), bus_m.ser_valid, tbl[i].sv);
      cmp($sformatf("tbl[%0d].ser_out", i),   bus_m.ser_out,   tbl[i].so);
      cmp($sformatf("tbl[%0d].done", i),      bus_m.done,      tbl[i].dn);
    end

    // LSB-first 8'h06 and a 0110 detector on the serial stream
    exp4 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    hist = 4'b0000;
    det  = -1;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 8'h06, 1'b0);
      seen[i] = bus_l.ser_out;
      hist = {hist[2:0], seen[i]};
      if (hist == 4'b0110 && det < 0) det = i + 1;
      cmp($sformatf("lsb06.bit%0d", i), seen[i], exp4[i]);
    end
    cmp("lsb06.detect_at", det, 4);
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // clr has priority over a transfer while idle
    step(1'b1, 8'hAA, 1'b1);
    cmp("clr_idle.ser_valid", bus_m.ser_valid, 1'b0);

    // clr during bit 3 of 8'hFF, then a fresh word emitted in full
    step(1'b1, 8'hFF, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    cmp("clr.ser_valid", bus_m.ser_valid, 1'b0);
    cmp("clr.busy",      bus_m.busy,      1'b0);
    cmp("clr.done",      bus_m.done,      1'b0);
    step(1'b1, 8'h5A, 1'b0);
    nv = bus_m.ser_valid ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (bus_m.ser_valid) nv++;
    end
    cmp("after_clr.valid_cycles", nv, LAST_IDX + 1);

    // Asynchronous reset in the middle of a word
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    idx  = -1;
    init = 1'b0;
    check_out();
    cmp("midrst.s_ready", bus_m.s_ready, 1'b0);
    repeat (2) @(posedge clk);
    release_reset();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 19) == 0));
    end

    // s_valid low for a long stretch: stays idle
    repeat (20) step(1'b0, W'($urandom), 1'b0);
    cmp("quiet.busy",    bus_m.busy,    1'b0);
    cmp("quiet.ser_out", bus_m.ser_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
